// File: rtl/time_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | time_counter: BCD hh:mm:ss counter with button-driven set mode.             |
// | Optional set-mode blink via macro TIME_COUNTER_BLINK_EN.   Revision: 1.0    |
// +-----------------------------------------------------------------------------+
module time_counter #(
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       ena_5hz,
  input  logic       set_btn,
  input  logic       inc_btn,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       day_pulse
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
  localparam logic [1:0] SET_SEC = 2'd3;

  localparam logic [7:0] HR_MAX = {4'((HOUR_MOD - 1) / 10), 4'((HOUR_MOD - 1) % 10)};
  localparam logic [7:0] MS_MAX = 8'h59;

  logic       set_q, inc_q, set_arm_q, inc_arm_q;
  logic       set_arm_d, inc_arm_d;
  logic       set_ev, inc_ev;
  logic [1:0] mode_q, mode_d;
  logic [7:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic       day_pulse_q, day_pulse_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // The arm flag stays low while a button is held through reset, so that press yields no event.
  assign set_ev    = set_btn & ~set_q & set_arm_q;
  assign inc_ev    = inc_btn & ~inc_q & inc_arm_q;
  assign set_arm_d = set_arm_q | ~set_btn;
  assign inc_arm_d = inc_arm_q | ~inc_btn;

  always_comb begin
    mode_d      = mode_q;
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    day_pulse_d = 1'b0;
    if (set_ev) begin
      mode_d = mode_q + 2'd1;
      if (mode_q == SET_SEC)
        sec_d = 8'h00;
    end else if (mode_q == RUN) begin
      if (ena) begin
        sec_d = bcd_inc(sec_q, MS_MAX);
        if (sec_q == MS_MAX) begin
          min_d = bcd_inc(min_q, MS_MAX);
          if (min_q == MS_MAX) begin
            hr_d        = bcd_inc(hr_q, HR_MAX);
            day_pulse_d = (hr_q == HR_MAX);
          end
        end
      end
    end else if (inc_ev) begin
      case (mode_q)
        SET_HR:  hr_d  = bcd_inc(hr_q, HR_MAX);
        SET_MIN: min_d = bcd_inc(min_q, MS_MAX);
        default: sec_d = bcd_inc(sec_q, MS_MAX);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_q       <= 1'b0;
      inc_q       <= 1'b0;
      set_arm_q   <= ~set_btn;
      inc_arm_q   <= ~inc_btn;
      mode_q      <= RUN;
      hr_q        <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      day_pulse_q <= 1'b0;
    end else begin
      set_q       <= set_btn;
      inc_q       <= inc_btn;
      set_arm_q   <= set_arm_d;
      inc_arm_q   <= inc_arm_d;
      mode_q      <= mode_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign mode      = mode_q;
  assign day_pulse = day_pulse_q;

`ifdef TIME_COUNTER_BLINK_EN
  logic blink_q, blink_d, blank;

  always_comb begin
    blink_d = blink_q;
    if (mode_d == RUN)
      blink_d = 1'b0;
    else if (inc_ev && !set_ev)
      blink_d = 1'b0;
    else if (ena_5hz)
      blink_d = ~blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      blink_q <= 1'b0;
    else
      blink_q <= blink_d;
  end

  assign blank   = blink_q && (mode_q != RUN);
  assign hr_bcd  = (blank && mode_q == SET_HR)  ? 8'hFF : hr_q;
  assign min_bcd = (blank && mode_q == SET_MIN) ? 8'hFF : min_q;
  assign sec_bcd = (blank && mode_q == SET_SEC) ? 8'hFF : sec_q;
`else
  logic unused_ena_5hz;
  assign unused_ena_5hz = ena_5hz;
  assign hr_bcd  = hr_q;
  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
`endif

endmodule
`default_nettype wire
